uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side byte buffer and launch controller sitting directly upstream of `uart_transmission`. Accepts bytes from the user/register write path into a circular FIFO and presents them one at a time on the transmitter's data/start inputs. Holds each byte stable for the whole frame, then waits for the transmitter's clear request before releasing the next byte. The transmitter launches on a rising edge of start.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `ADDR_W`, 4: pointer width; must equal log2(`DEPTH`).
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `wr_en` input 1: push request; one byte per cycle.
- `wr_data` input 8: byte to push.
- `flush` input 1: synchronous FIFO clear.
- `full` output 1: count == `DEPTH`.
- `empty` output 1: count == 0.
- `level` output `ADDR_W`+1: current entry count.
- `tx_data` output 8: to transmitter `i_tx_data`; registered.
- `tx_start` output 1: to transmitter `i_tx_start`; registered.
- `tx_clear_req` input 1: from transmitter `o_clear_req`; frame done.
- `tx_busy` input 1: from transmitter `o_busy`.
- `ovf` output 1: sticky overflow flag; present only with the macro.
- `ovf_clr` input 1: clears `ovf`; present only with the macro.

## Operation
- Storage: `DEPTH` x 8 array with `ADDR_W`-bit write and read pointers that wrap naturally. Count is `ADDR_W`+1 bits.
- Push is accepted iff `wr_en`=1, registered count < `DEPTH`, and `flush`=0. Otherwise the write is dropped.
- Pop occurs only on the IDLE->SEND transition.
- Simultaneous push and pop: both take effect and count is unchanged.
  - When full, a push is rejected even if a pop occurs in the same cycle.
- `flush`: pointers and count go to 0 on the next edge. The byte already latched in `tx_data` is not aborted; the FSM completes its current frame.
- FSM states:
  - IDLE: `tx_start`=0. Moves to SEND when count != 0, `tx_busy`=0 and `flush`=0. On that edge, `tx_data` takes the FIFO head and the read pointer advances.
  - SEND: `tx_start`=1; `tx_data` is held. Moves to GAP when `tx_clear_req`=1.
  - GAP: `tx_start`=0 for exactly 2 cycles, counted by a 1-bit counter. This lets the transmitter's 2-stage edge detector see a low level. Then returns to IDLE.
- Illegal state encoding: return to IDLE with `tx_start`=0.
- Reset values: `tx_data`=8'h00, `tx_start`=0, `full`=0, `empty`=1, `level`=0, `ovf`=0, state IDLE, pointers 0.
- Reset mid-frame: everything returns to reset values asynchronously and buffered bytes are lost. The transmitter shares `rst_n`, so no handshake recovery is needed.

## Timing
- `full`, `empty` and `level` are registered and reflect pushes and pops one edge later.
- Write-to-start latency with an empty FIFO, IDLE state and `tx_busy`=0:
  - `wr_en` in cycle 0 gives count=1 after edge 1.
  - The FSM moves to SEND at edge 2.
  - `tx_start` is high from cycle 2.
- `tx_data` changes only on the IDLE->SEND edge, never while in SEND or GAP.
- Back-to-back frames: the minimum gap from `tx_clear_req` to the next rising `tx_start` is 4 cycles: clear edge, GAP x2, IDLE evaluation.
- Full throughput: one byte per frame. Pushes are accepted at one per cycle until full.

## Configuration
- Macro: `UART_TX_FIFO_OVF_EN`.
- Defined:
  - `ovf` and `ovf_clr` ports exist.
  - `ovf` sets on the edge after any rejected push where `wr_en`=1 and full.
  - `ovf` stays high until `ovf_clr`=1.
  - If set and clear occur in the same cycle, set wins.
- Undefined: the ports and logic are absent, and rejected pushes are silently dropped.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding constants: IDLE=2'd0, SEND=2'd1, GAP=2'd2.
  - The GAP length constant (2).
  - Default `DEPTH`/`ADDR_W`.
- Sub-module `uart_sync_fifo`: storage, pointers, count, `full`/`empty`/`level` and the overflow logic. The top level holds the launch FSM and the `tx_data`/`tx_start` registers.

## Test plan
- Reset with `wr_en`=0: `empty`=1, `level`=0, `tx_start`=0, `tx_data`=8'h00.
- Push 8'hA5 to an idle, empty FIFO with the transmitter model idle -> `tx_start` rises 2 cycles later with `tx_data`=8'hA5, holds until `tx_clear_req`, and is low for 2 GAP cycles.
- Push 8'h01, 8'h02, 8'h03 back-to-back -> the transmitter model receives 01, 02, 03 in order; each start is a clean 0->1 edge; `tx_data` never changes during SEND.
- Fill 16 entries, then push 8'hFF -> `full`=1, `level`=16, 8'hFF dropped. With the macro, `ovf`=1 until `ovf_clr`.
- At full, pop and push in the same cycle -> push rejected, `level`=15. At `level`=3, pop and push together -> `level` stays 3.
- Assert `flush` during SEND with 5 queued -> current byte completes, `level`=0, no further `tx_start`. Assert `rst_n`=0 mid-frame -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
//
// Purpose: launch FSM state encoding, GAP length, default FIFO geometry.
// Ports:   none (package).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  // Low cycles inserted after each frame so the transmitter's
  // two-stage edge detector sees tx_start drop before the next launch.
  localparam int GAP_LEN = 2;

  localparam int DEFAULT_DEPTH  = 16;
  localparam int DEFAULT_ADDR_W = 4;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - write-side and transmitter-side bundle for uart_tx_fifo
//
// Purpose: groups the byte-push path, FIFO status and transmitter handshake.
// Modports:
//   slave  - uart_tx_fifo view: takes wr_en/wr_data/flush/tx_clear_req/tx_busy,
//            drives full/empty/level/tx_data/tx_start.
//   master - user + transmitter view (opposite directions).
// Optional: ovf/ovf_clr exist only when UART_TX_FIFO_OVF_EN is defined.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic            wr_en;
  logic [7:0]      wr_data;
  logic            flush;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] level;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            tx_clear_req;
  logic            tx_busy;
`ifdef UART_TX_FIFO_OVF_EN
  logic            ovf;
  logic            ovf_clr;

  modport slave (
    input  wr_en, wr_data, flush, tx_clear_req, tx_busy, ovf_clr,
    output full, empty, level, tx_data, tx_start, ovf
  );

  modport master (
    output wr_en, wr_data, flush, tx_clear_req, tx_busy, ovf_clr,
    input  full, empty, level, tx_data, tx_start, ovf
  );
`else
  modport slave (
    input  wr_en, wr_data, flush, tx_clear_req, tx_busy,
    output full, empty, level, tx_data, tx_start
  );

  modport master (
    output wr_en, wr_data, flush, tx_clear_req, tx_busy,
    input  full, empty, level, tx_data, tx_start
  );
`endif

endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - circular byte FIFO feeding the UART launch FSM
//
// Purpose: DEPTH x 8 storage, wrapping pointers, registered count/full/empty,
//          optional sticky overflow flag (UART_TX_FIFO_OVF_EN).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   wr_en, wr_data    push request and byte
//   flush             synchronous clear of pointers and count
//   rd_en, rd_data    pop request, head byte (combinational read)
//   full, empty       registered status flags
//   level             registered entry count
//   ovf_clr, ovf      overflow clear / sticky flag (macro only)
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  input  logic            flush,
  input  logic            rd_en,
  output logic [7:0]      rd_data,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] level
`ifdef UART_TX_FIFO_OVF_EN
  ,
  input  logic            ovf_clr,
  output logic            ovf
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              full_q;
  logic              empty_q;
  logic              push;
  logic              pop;

  // Acceptance uses the registered full flag, so a pop in the same cycle
  // never makes room for a push at full.
  assign push = wr_en && !full_q && !flush;
  assign pop  = rd_en && !empty_q && !flush;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = count_q;

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;

  // Set has priority over clear so an overflow in the clearing cycle is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (wr_en && full_q) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit byte buffer and launch controller for uart_transmission
//
// Purpose: buffers user bytes and launches them one per frame on tx_data/tx_start,
//          holding each byte for the whole frame and inserting a low gap after
//          the transmitter's clear request.
// Ports:
//   clk, rst_n   clock, async active-low reset (shared with the transmitter)
//   bus          uart_tx_fifo_if.slave: wr_en/wr_data/flush in, full/empty/level out,
//                tx_data/tx_start out, tx_clear_req/tx_busy in,
//                ovf_clr in / ovf out when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  bus
);

  localparam logic GAP_LAST = 1'(GAP_LEN - 1);

  tx_state_t  state_q;
  tx_state_t  state_d;
  logic       gap_cnt_q;
  logic       gap_cnt_d;
  logic       launch;
  logic       fifo_empty;
  logic [7:0] head_data;
  logic [7:0] tx_data_q;
  logic       tx_start_q;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .flush   (bus.flush),
    .rd_en   (launch),
    .rd_data (head_data),
    .full    (bus.full),
    .empty   (fifo_empty),
    .level   (bus.level)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .ovf_clr (bus.ovf_clr),
    .ovf     (bus.ovf)
`endif
  );

  assign bus.empty = fifo_empty;

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    launch    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !bus.tx_busy && !bus.flush) begin
          state_d = SEND;
          launch  = 1'b1;
        end
      end
      SEND: begin
        if (bus.tx_clear_req) begin
          state_d   = GAP;
          gap_cnt_d = 1'b0;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = IDLE;
          gap_cnt_d = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        gap_cnt_d = 1'b0;
      end
    endcase
  end

  // tx_start is registered from the next state so it rises on the same edge
  // that pops the head into tx_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gap_cnt_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_start_q <= (state_d == SEND);
      if (launch) tx_data_q <= head_data;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a transmitter model
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic       hold_busy = 1'b0;
  logic       txm_busy  = 1'b0;
  assign bus.tx_busy = txm_busy | hold_busy;

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_m      = 1'b0;
  logic ovf_clr_v  = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Transmitter model: on a start, stay busy a random frame length,
  // pulse clear for one cycle, then drop busy.
  initial begin
    bus.tx_clear_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.tx_start && !txm_busy) begin
        txm_busy = 1'b1;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        bus.tx_clear_req = 1'b1;
        @(negedge clk);
        bus.tx_clear_req = 1'b0;
        txm_busy = 1'b0;
      end
    end
  end

  // Monitor: every rising start pops the scoreboard; tx_data must otherwise hold.
  int         starts  = 0;
  int         low_run = 0;
  int         gap_min = 1000;
  bit         had_frame = 1'b0;
  logic       mon_prev  = 1'b0;
  logic [7:0] held      = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.tx_start && !mon_prev) begin
          starts++;
          if (had_frame) begin
            chk("start_gap_min3", 32'(low_run >= 3), 1);
            if (low_run < gap_min) gap_min = low_run;
          end
          chk("start_has_data", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) chk("tx_data_order", bus.tx_data, exp_q.pop_front());
          held      = bus.tx_data;
          had_frame = 1'b1;
          low_run   = 0;
        end else begin
          chk("tx_data_hold", bus.tx_data, held);
          if (!bus.tx_start) low_run++;
        end
        mon_prev = bus.tx_start;
      end
    end
  end

  // One clock of stimulus, called at negedge+1. Status is checked first
  // against the model, then the next push/flush is decided and applied.
  task automatic cycle(input logic we, input logic [7:0] d, input logic fl);
    chk("level", bus.level, exp_q.size());
    chk("full",  bus.full,  32'(exp_q.size() == DEPTH));
    chk("empty", bus.empty, 32'(exp_q.size() == 0));
`ifdef UART_TX_FIFO_OVF_EN
    chk("ovf", bus.ovf, ovf_m);
    bus.ovf_clr = ovf_clr_v;
    if (we && exp_q.size() == DEPTH) ovf_m = 1'b1;
    else if (ovf_clr_v)              ovf_m = 1'b0;
`endif
    bus.wr_en   = we;
    bus.wr_data = d;
    bus.flush   = fl;
    if (fl) exp_q.delete();
    else if (we && exp_q.size() < DEPTH) exp_q.push_back(d);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_quiet();
    int q = 0;
    int n = 0;
    while (q < 4 && n < 400) begin
      cycle(1'b0, 8'h00, 1'b0);
      n++;
      if (!bus.tx_start && !txm_busy && (hold_busy || exp_q.size() == 0)) q++;
      else q = 0;
    end
    chk("quiet_reached", 32'(q >= 4), 1);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!bus.tx_start && n < 40) begin
      cycle(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("start_seen", bus.tx_start, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic we;
    logic fl;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.flush   = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    bus.ovf_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_empty",    bus.empty,    1);
    chk("rst_level",    bus.level,    0);
    chk("rst_full",     bus.full,     0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_data",  bus.tx_data,  8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Single byte: start two edges after the push.
    cycle(1'b1, 8'hA5, 1'b0);
    chk("lat_start_e1", bus.tx_start, 0);
    chk("lat_level_e1", bus.level,    1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("lat_start_e2", bus.tx_start, 1);
    chk("lat_data_e2",  bus.tx_data,  8'hA5);
    wait_quiet();

    // Back-to-back frames: low run between frames is GAP x2 + IDLE.
    gap_min = 1000;
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    cycle(1'b1, 8'h03, 1'b0);
    wait_quiet();
    chk("b2b_gap", gap_min, 3);

    // Fill to full, then overflow push.
    hold_busy = 1'b1;
    wait_quiet();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'h10 + i[7:0], 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    chk("full_set",   bus.full,  1);
    chk("full_level", bus.level, DEPTH);
`ifdef UART_TX_FIFO_OVF_EN
    chk("ovf_set", bus.ovf, 1);
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    chk("ovf_sticky", bus.ovf, 1);
    ovf_clr_v = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    ovf_clr_v = 1'b0;
    chk("ovf_cleared", bus.ovf, 0);
`endif

    // Pop and push together at full: push rejected.
    hold_busy = 1'b0;
    cycle(1'b1, 8'hEE, 1'b0);
    chk("fullpop_level", bus.level, DEPTH - 1);
    chk("fullpop_full",  bus.full,  0);
    hold_busy = 1'b1;
    wait_quiet();

    // Pop and push together at level 3: level unchanged.
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h31, 1'b0);
    cycle(1'b1, 8'h32, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    hold_busy = 1'b0;
    cycle(1'b1, 8'h77, 1'b0);
    chk("popush_level", bus.level, 3);
    wait_quiet();

    // Flush while sending with 5 still queued.
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'h50 + i[7:0], 1'b0);
    hold_busy = 1'b0;
    wait_start();
    chk("flush_pre_level", bus.level, 5);
    s0 = starts;
    cycle(1'b0, 8'h00, 1'b1);
    chk("flush_level0", bus.level, 0);
    wait_quiet();
    chk("flush_no_start",  starts,      s0);
    chk("flush_data_kept", bus.tx_data, 8'h50);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      we = ($urandom_range(0, 99) < 60);
      fl = ($urandom_range(0, 99) < 2);
      hold_busy = ($urandom_range(0, 99) < 10);
`ifdef UART_TX_FIFO_OVF_EN
      ovf_clr_v = ($urandom_range(0, 99) < 5);
`endif
      cycle(we, 8'($urandom), fl);
    end
    hold_busy = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    ovf_clr_v = 1'b0;
`endif
    wait_quiet();

    // Reset in the middle of a frame.
    cycle(1'b1, 8'hC3, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b1, 8'h99, 1'b0);
    wait_start();
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_start", bus.tx_start, 0);
    chk("midrst_tx_data",  bus.tx_data,  8'h00);
    chk("midrst_level",    bus.level,    0);
    chk("midrst_empty",    bus.empty,    1);
    chk("midrst_full",     bus.full,     0);
`ifdef UART_TX_FIFO_OVF_EN
    chk("midrst_ovf",      bus.ovf,      0);
`endif
    exp_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
